// File: rtl/noc_vc_sched_pkg.sv
// Shared types and constants for the NoC virtual-channel scheduler.
// The packet-lock feature is enabled with NOC_VC_SCHED_PKTLOCK_EN.
package noc_vc_sched_pkg;

  localparam int unsigned NUM_VC_MAX = 16;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Position of the last-flit marker within a flit of the given width.
  function automatic int unsigned flit_tail_bit(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/noc_vc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after 'last' wins, with an explicit modulo wrap.
module rr_arbiter
  import noc_vc_sched_pkg::*;
#(
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned VCW    = $clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [VCW-1:0]    last,
  output logic [NUM_VC-1:0] gnt,
  output logic [VCW-1:0]    idx,
  output logic              any
);

  localparam int unsigned SCAN = (NUM_VC < NUM_VC_MAX) ? NUM_VC : NUM_VC_MAX;

  always_comb begin : search
    int unsigned cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned i = 1; i <= SCAN; i++) begin
      cand = 32'(last) + i;
      if (cand >= NUM_VC) cand = cand - NUM_VC;
      if (!any && req[VCW'(cand)]) begin
        any              = 1'b1;
        idx              = VCW'(cand);
        gnt[VCW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_vc_sched.sv
// Round-robin drain of NUM_VC FWFT FIFOs onto one registered valid/ready link.
// Define NOC_VC_SCHED_PKTLOCK_EN to hold the grant on one VC until a tail flit passes.
module noc_vc_sched
  import noc_vc_sched_pkg::*;
#(
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned VCW    = $clog2(NUM_VC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_VC-1:0]             i_fifo_empty,
  input  logic [NUM_VC-1:0][WIDTH-1:0]  i_fifo_rdata,
  output logic [NUM_VC-1:0]             o_fifo_pop,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [WIDTH-1:0]              o_data,
  output logic [VCW-1:0]                o_vc
);

  logic              load_c;
  logic              any_c;
  logic [NUM_VC-1:0] elig_c;
  logic [NUM_VC-1:0] gnt_c;
  logic [VCW-1:0]    gidx_c;
  logic [VCW-1:0]    rr_last;
  logic [WIDTH-1:0]  head_c;

  assign load_c = !o_valid || i_ready;
  assign head_c = i_fifo_rdata[gidx_c];

`ifdef NOC_VC_SCHED_PKTLOCK_EN
  localparam int unsigned TAIL = flit_tail_bit(WIDTH);

  lock_state_e    lock_q;
  logic [VCW-1:0] lock_vc;

  // While a packet is in flight only its own VC may be served.
  always_comb begin
    elig_c = ~i_fifo_empty;
    if (lock_q == LOCKED) elig_c = elig_c & (NUM_VC'(1) << lock_vc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= UNLOCKED;
      lock_vc <= '0;
    end else if (load_c && any_c) begin
      if (lock_q == UNLOCKED && !head_c[TAIL]) begin
        lock_q  <= LOCKED;
        lock_vc <= gidx_c;
      end else if (lock_q == LOCKED && head_c[TAIL]) begin
        lock_q  <= UNLOCKED;
      end
    end
  end
`else
  assign elig_c = ~i_fifo_empty;
`endif

  rr_arbiter #(
    .NUM_VC (NUM_VC),
    .VCW    (VCW)
  ) u_arb (
    .req  (elig_c),
    .last (rr_last),
    .gnt  (gnt_c),
    .idx  (gidx_c),
    .any  (any_c)
  );

  // Pop only when the winner's flit is actually captured this edge.
  assign o_fifo_pop = (load_c && any_c && !rst) ? gnt_c : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_vc    <= '0;
      rr_last <= VCW'(NUM_VC - 1);
    end else if (load_c) begin
      if (any_c) begin
        o_valid <= 1'b1;
        o_data  <= head_c;
        o_vc    <= gidx_c;
        rr_last <= gidx_c;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/noc_vc_sched.md
# noc_vc_sched

Round-robin scheduler that drains up to NUM_VC first-word-fall-through FIFOs (`fifo32` with RLATENCY=0) onto one shared NoC output link. It generates each FIFO's pop, muxes the selected head flit into a registered output stage, and presents it on a valid/ready handshake. It sits between the per-virtual-channel input buffers of a router port and the downstream link or crossbar.

## Interface
Parameters:
- `NUM_VC`, default 4: number of FIFOs served; legal range 2..16.
- `WIDTH`, default 32: flit width; bit `WIDTH-1` is the tail (last-flit) marker.
- `VCW`, default `$clog2(NUM_VC)`: VC index width; derived, not overridden.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `i_fifo_empty`  in  NUM_VC: per-FIFO `o_empty`.
- `i_fifo_rdata`  in  NUM_VC x WIDTH: per-FIFO head data (FWFT).
- `o_fifo_pop`  out  NUM_VC: per-FIFO `i_pop`; combinational, at most one bit high per cycle.
- `o_valid`  out  1: output flit valid (registered).
- `i_ready`  in  1: downstream accepts this cycle.
- `o_data`  out  WIDTH: output flit (registered).
- `o_vc`  out  VCW: source FIFO index of `o_data` (registered).

## Operation
- Output stage can load when `!o_valid || i_ready`.
- Eligible set is `~i_fifo_empty`, with the lock filter applied when packet lock is compiled in.
- Grant selection:
  - Round-robin pointer `rr_last` holds the last granted index.
  - Search order is `rr_last+1`, `rr_last+2`, … modulo NUM_VC; the first eligible index wins.
- Pop: when the stage can load and some FIFO is eligible, assert `o_fifo_pop[g]` for winner `g`.
- On that same edge: `o_data <= i_fifo_rdata[g]`, `o_vc <= g`, `o_valid <= 1`, `rr_last <= g`.
- If the stage can load but nothing is eligible, then `o_valid <= 0` on the next edge.
- A pop never targets an empty FIFO. `o_fifo_pop` is zero whenever the stage cannot load.
- `o_data` and `o_vc` hold stable while `o_valid && !i_ready`.
- Modulo wrap: index NUM_VC-1 is followed by 0. For non-power-of-2 NUM_VC, the wrap is explicit, not bit truncation.

## Timing
- Reset values: `o_valid=0`, `o_data=0`, `o_vc=0`, `rr_last=NUM_VC-1` so VC0 has first priority, lock cleared. `o_fifo_pop=0` while `rst` is high.
- Latency: FIFO head to `o_valid` is 1 cycle.
- Throughput is 1 flit/cycle when `i_ready` is held high and any FIFO is non-empty.
- Back-to-back pops from one FIFO are legal. The FIFO's registered `o_empty` guarantees correctness; the scheduler adds no extra bubble.
- Reset asserted mid-transfer discards the output register contents and any lock, with no partial state retained.
- Simultaneous load and `i_ready`: the old flit is consumed and the new flit is loaded on the same edge.

## Configuration
- Macro `NOC_VC_SCHED_PKTLOCK_EN`.
- Defined: packet lock.
  - Two states: UNLOCKED and LOCKED(vc).
  - UNLOCKED → LOCKED(g) when a flit with `data[WIDTH-1]=0` is popped from `g`.
  - LOCKED(v) → UNLOCKED when a flit with tail bit 1 is popped from `v`.
  - While LOCKED(v), only `v` is eligible. If `v` is empty, nothing is popped (stall); other VCs are not served.
  - A single-flit packet (tail=1 on the first flit) never enters LOCKED.
- Undefined: every flit re-arbitrates independently, and the tail bit is passed through as ordinary data.

## Structure
- Package `noc_vc_sched_pkg`:
  - `NUM_VC_MAX=16`.
  - `FLIT_TAIL_BIT` offset convention: `WIDTH-1`.
  - Lock state enum `lock_state_e` {UNLOCKED, LOCKED}.
- Sub-module `rr_arbiter`: parameterized NUM_VC; inputs `req` and `last`; outputs one-hot `gnt`, index, and `any`. It is purely combinational and reusable by other router ports.
- The top holds the output register, `rr_last`, lock state/vc, and pop gating.

## Test plan
- Reset, then FIFOs 0 and 2 non-empty, `i_ready=1`:
  - First pop goes to VC0; `o_valid` rises 1 cycle later with `o_vc=0`.
  - Next grant is VC2, then VC0, alternating.
- All 4 FIFOs holding 3 flits each, `i_ready=1`: `o_vc` sequence is 0,1,2,3,0,1,2,3,0,1,2,3 with no bubbles, then `o_valid=0`.
- `i_ready=0` for 5 cycles with a flit in the output stage:
  - `o_fifo_pop=0` throughout; `o_data`/`o_vc` stable.
  - On release, the next flit follows immediately.
- Reset pulsed while `o_valid=1`:
  - Next cycle `o_valid=0`, `o_vc=0`.
  - After reset, VC0 is first priority again.
- With `NOC_VC_SCHED_PKTLOCK_EN`: VC1 holds a 3-flit packet (tail on the 3rd) and VC0 is non-empty.
  - All 3 VC1 flits go out consecutively, then VC0.
  - If VC1 goes empty after flit 2, no pops occur until VC1 refills.
- Without the macro, the same stimulus interleaves VC0 and VC1 flit-by-flit.
